// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the lc3b memory-port arbiter: word/mask types, FSM states
// and the byte-mask selection used when a data request owns the port.
package mem_port_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Reads always fetch the full word; only writes honour the requester's mask.
  function automatic lc3b_mem_wmask wmask_for(input logic write, input lc3b_mem_wmask be);
    return write ? be : 2'b11;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and physical-memory signals around the arbiter.
// Handshake: a requester holds read/write until its resp pulse; mem_resp is a one-cycle completion.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic          i_read;
  lc3b_word      i_address;
  lc3b_word      i_rdata;
  logic          i_resp;

  logic          d_read;
  logic          d_write;
  lc3b_mem_wmask d_byte_enable;
  lc3b_word      d_address;
  lc3b_word      d_wdata;
  lc3b_word      d_rdata;
  logic          d_resp;

  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
           mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
           mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output arb_state_t           state_o,
  output logic [CNT_W-1:0]     starve_cnt_o
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             d_req;
  logic             starved;
  logic [CNT_W-1:0] cnt_inc;

  assign d_req   = bus.d_read | bus.d_write;
  assign starved = bus.i_read && (starve_cnt_q >= CNT_W'(STARVE_LIMIT));
  assign cnt_inc = (starve_cnt_q == '1) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);

  // Requests are only sampled in IDLE; the counter is updated at data-grant time.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req && !starved) begin
          state_d      = SERVE_D;
          starve_cnt_d = bus.i_read ? cnt_inc : '0;
        end else if (bus.i_read) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp) begin
          state_d      = IDLE;
          starve_cnt_d = '0;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Port mux decodes straight from the state flop, so reset silences it immediately.
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.i_resp          = 1'b0;
    bus.d_resp          = 1'b0;
    bus.i_rdata         = bus.mem_rdata;
    bus.d_rdata         = bus.mem_rdata;
    case (state_q)
      SERVE_I: begin
        bus.mem_read        = 1'b1;
        bus.mem_address     = bus.i_address;
        bus.mem_byte_enable = 2'b11;
        bus.i_resp          = bus.mem_resp;
      end
      SERVE_D: begin
        bus.mem_read        = bus.d_read & ~bus.d_write;
        bus.mem_write       = bus.d_write;
        bus.mem_address     = bus.d_address;
        bus.mem_wdata       = bus.d_wdata;
        bus.mem_byte_enable = wmask_for(bus.d_write, bus.d_byte_enable);
        bus.d_resp          = bus.mem_resp;
      end
      default: ;
    endcase
  end

  assign state_o      = state_q;
  assign starve_cnt_o = starve_cnt_q;

  // A simultaneous read+write is served as a write but flagged in simulation.
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(bus.d_read && bus.d_write))
    else $error("d_read and d_write asserted together");
  a_one_resp: assert property (@(posedge clk) disable iff (!rst_n) !(bus.i_resp && bus.d_resp))
    else $error("i_resp and d_resp asserted together");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: tasks drive the requesters and memory,
// a monitor pops expected {owner, address, rdata} entries on every response.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W = 33;

  logic       clk;
  logic       rst_n;
  arb_state_t state_o;
  logic [3:0] starve_cnt_o;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .state_o      (state_o),
    .starve_cnt_o (starve_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (bus.i_resp || bus.d_resp)) begin
      if (bus.i_resp && bus.d_resp) begin
        chk("dual_resp", {bus.i_resp, bus.d_resp}, 2'b10);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_resp", {bus.d_resp, bus.mem_address}, 40'h0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("resp", {bus.d_resp, bus.mem_address, bus.d_resp ? bus.d_rdata : bus.i_rdata}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_strobes(input bit is_d, input bit wr, input logic [1:0] be,
                               input logic [15:0] addr, input logic [15:0] wdata);
    chk("mem_read",  bus.mem_read,  !(is_d && wr));
    chk("mem_write", bus.mem_write, is_d && wr);
    chk("mem_addr",  bus.mem_address, addr);
    chk("mem_be",    bus.mem_byte_enable, (is_d && wr) ? be : 2'b11);
    if (is_d) chk("mem_wdata", bus.mem_wdata, wdata);
  endtask

  // One transaction: request at cycle 0, wait_cyc bare cycles, resp, then IDLE.
  task automatic run_txn(input bit is_d, input bit wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int wait_cyc);
    cyc();
    if (is_d) begin
      bus.d_read = !wr; bus.d_write = wr; bus.d_byte_enable = be;
      bus.d_address = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_read = 1'b1; bus.i_address = addr;
    end
    exp_q.push_back({is_d, addr, rdata});
    for (int k = 0; k < wait_cyc; k++) begin
      cyc(); #3;
      check_strobes(is_d, wr, be, addr, wdata);
    end
    cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = rdata;
    #3;
    check_strobes(is_d, wr, be, addr, wdata);
    cyc();
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.mem_resp = 1'b0;
    #3;
    chk("post_state", state_o, IDLE);
    chk("post_strobe", {bus.mem_read, bus.mem_write}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  arb_state_t st_tab[10] = '{SERVE_D, IDLE, SERVE_D, IDLE, SERVE_D, IDLE,
                             SERVE_D, IDLE, SERVE_I, IDLE};
  int         cnt_tab[10] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 0};

  initial begin
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_byte_enable = 2'b00;
    bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = 16'hBEEF; bus.mem_resp = 1'b0;
    #3;
    chk("rst_state", state_o, IDLE);
    chk("rst_cnt", starve_cnt_o, 4'd0);
    chk("rst_strobes", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 4'b0000);
    chk("rst_be", bus.mem_byte_enable, 2'b00);
    chk("rst_addr", bus.mem_address, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_i_rdata", bus.i_rdata, 16'hBEEF);
    chk("rst_d_rdata", bus.d_rdata, 16'hBEEF);
    cyc(); cyc();
    rst_n = 1'b1;

    // Lone fetch: strobes cycles 1..3, response at cycle 3.
    run_txn(1'b0, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1234, 2);

    // Simultaneous fetch + data read: data first, fetch after the IDLE cycle.
    cyc();
    bus.i_read = 1'b1; bus.i_address = 16'h0100;
    bus.d_read = 1'b1; bus.d_address = 16'h0200;
    exp_q.push_back({1'b1, 16'h0200, 16'h1111});
    exp_q.push_back({1'b0, 16'h0100, 16'h2222});
    cyc(); #3;
    chk("sim_state_d", state_o, SERVE_D);
    chk("sim_addr_d", bus.mem_address, 16'h0200);
    cyc(); bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1111;
    cyc(); bus.d_read = 1'b0; bus.mem_resp = 1'b0;
    #3;
    chk("sim_idle", state_o, IDLE);
    chk("sim_cnt1", starve_cnt_o, 4'd1);
    cyc(); #3;
    chk("sim_state_i", state_o, SERVE_I);
    chk("sim_addr_i", bus.mem_address, 16'h0100);
    cyc(); bus.mem_resp = 1'b1; bus.mem_rdata = 16'h2222;
    cyc(); bus.i_read = 1'b0; bus.mem_resp = 1'b0;
    #3;
    chk("sim_cnt0", starve_cnt_o, 4'd0);

    // Byte write and an immediate-response data read.
    run_txn(1'b1, 1'b1, 2'b01, 16'h2001, 16'h00AB, 16'h0000, 2);
    run_txn(1'b1, 1'b0, 2'b00, 16'h0500, 16'h7777, 16'hC0DE, 0);

    // Starvation: both requests held, memory always responding.
    cyc();
    bus.i_read = 1'b1; bus.i_address = 16'h0300;
    bus.d_read = 1'b1; bus.d_address = 16'h0400;
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'h5A5A;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 16'h0400, 16'h5A5A});
    exp_q.push_back({1'b0, 16'h0300, 16'h5A5A});
    for (int c = 0; c < 10; c++) begin
      cyc(); #3;
      chk($sformatf("starve_state%0d", c + 1), state_o, st_tab[c]);
      chk($sformatf("starve_cnt%0d", c + 1), starve_cnt_o, cnt_tab[c][3:0]);
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.mem_resp = 1'b0;

    // Reset in the middle of a data write; the late response must be dropped.
    cyc();
    bus.d_write = 1'b1; bus.d_byte_enable = 2'b11;
    bus.d_address = 16'h3000; bus.d_wdata = 16'h55AA;
    cyc(); #3;
    chk("rw_write1", bus.mem_write, 1'b1);
    cyc(); #3;
    chk("rw_write2", bus.mem_write, 1'b1);
    cyc();
    rst_n = 1'b0; bus.d_write = 1'b0;
    #1;
    chk("rw_write_drop", bus.mem_write, 1'b0);
    chk("rw_state_rst", state_o, IDLE);
    cyc();
    rst_n = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = 16'hDEAD;
    #3;
    chk("rw_no_dresp", bus.d_resp, 1'b0);
    chk("rw_state_rel", state_o, IDLE);
    cyc(); bus.mem_resp = 1'b0;
    #3;
    chk("rw_state_idle", state_o, IDLE);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("queue_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port of the lc3b pipeline between the fetch stage (read-only instruction port) and the mem stage (data read/write port).
- Grants one requester at a time and holds the grant until mem_resp.
- Data requests have priority; a starvation counter guarantees fetch forward progress.
- Sits between the fetch/mem stage instances and the top-level mem_* pins.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while a fetch request is pending before fetch is forced. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  fetch read request; held until i_resp
- i_address  in  16  fetch address (lc3b_word); stable while i_read
- i_rdata  out  16  fetch read data; valid when i_resp
- i_resp  out  1  fetch completion pulse
- d_read  in  1  data read request; held until d_resp
- d_write  in  1  data write request; held until d_resp
- d_byte_enable  in  2  write byte mask (lc3b_mem_wmask)
- d_address  in  16  data address
- d_wdata  in  16  write data
- d_rdata  out  16  data read data; valid when d_resp
- d_resp  out  1  data completion pulse
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_byte_enable  out  2  to memory
- mem_address  out  16  to memory
- mem_wdata  out  16  to memory
- mem_rdata  in  16  from memory
- mem_resp  in  1  from memory; one-cycle completion

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- States: IDLE, SERVE_I, SERVE_D. The state register and starve_cnt are the only flops.
- Reset (async, any time, including mid-transaction):
  - state=IDLE, starve_cnt=0.
  - mem_read, mem_write, i_resp, d_resp all 0 immediately.
  - A transaction in flight is abandoned; a memory response arriving after reset is ignored.
- Reset output values: mem_byte_enable=2'b00, mem_address=0, mem_wdata=0, i_rdata and d_rdata pass mem_rdata.
- IDLE:
  - All mem_* strobes are 0.
  - Next state: SERVE_D if d_req=(d_read|d_write) and not (i_read and starve_cnt>=STARVE_LIMIT); else SERVE_I if i_read; else IDLE.
- SERVE_I:
  - mem_read=1, mem_write=0, mem_address=i_address, mem_byte_enable=2'b11.
  - i_resp=mem_resp. On mem_resp, go to IDLE and set starve_cnt=0.
- SERVE_D:
  - mem_read=d_read&~d_write, mem_write=d_write, mem_address=d_address, mem_wdata=d_wdata.
  - mem_byte_enable=d_byte_enable on write, 2'b11 on read.
  - d_resp=mem_resp. On mem_resp, go to IDLE.
  - starve_cnt increments (saturating at 2^CNT_W-1) if i_read was high at grant; otherwise it clears.
- d_read and d_write both high is illegal: the request is treated as a write and a simulation assertion fires.
- Response routing:
  - i_resp and d_resp are never high in the same cycle.
  - A response is never delivered to the non-owner.
  - mem_resp in IDLE is ignored.
- Latency: request seen in IDLE at cycle t, strobe at t+1, earliest resp at t+1, IDLE again at t+2. Minimum 2 cycles per transaction.
- The mandatory IDLE cycle after each response lets the requester drop or change its request; a stale request is never re-granted.
- Requests are not sampled while in SERVE_x. A request dropped mid-transaction is illegal; the arbiter keeps driving the memory until mem_resp.
- Simultaneous i_read and d_req in IDLE: data wins unless the starvation limit is reached.

Decomposition:
- lc3b_types supplies lc3b_word and lc3b_mem_wmask.
- Add arb_state_t (enum IDLE/SERVE_I/SERVE_D) to lc3b_types.
- A single flat module is natural; no sub-module is needed. The output mux is inline combinational logic.

Test Plan:
- Reset mid-SERVE_D (write pending, rst_n low at cycle 3):
  - mem_write drops to 0 the same cycle.
  - A later mem_resp produces no d_resp.
  - State is IDLE after release.
- Lone fetch:
  - i_read=1, i_address=16'h0040, mem_rdata=16'h1234 with mem_resp at cycle 3.
  - Required: mem_read=1, mem_address=16'h0040 during cycles 1..3; i_resp=1 and i_rdata=16'h1234 at cycle 3; d_resp never set.
- Simultaneous requests:
  - i_read and d_read both asserted at cycle 0.
  - Required: data served first (mem_address=d_address); fetch granted in the IDLE cycle after d_resp.
- Byte write:
  - d_write=1, d_byte_enable=2'b01, d_address=16'h2001, d_wdata=16'h00AB.
  - Required: mem_write=1 with those exact values until mem_resp; mem_read=0 throughout.
- Starvation (STARVE_LIMIT=4):
  - d_read held continuously with immediate resps, i_read held.
  - Required: exactly 4 data grants, then 1 fetch grant, with starve_cnt back to 0.
